// File: rtl/note_sequencer_pwm_if.sv
// Interface bundling the MCU-side load signals and the speaker-side outputs
// of note_sequencer_pwm. The master drives ce/notes_flat/loop_en; the slave
// (the sequencer) drives pwm/making_music/done.
interface note_sequencer_pwm_if #(
  parameter int unsigned NUM_NOTES = 5,
  parameter int unsigned PITCH_W   = 4,
  parameter int unsigned DUR_W     = 4
);
  logic                                      ce;
  logic [NUM_NOTES*(PITCH_W+DUR_W)-1:0]      notes_flat;
  logic                                      loop_en;
  logic                                      pwm;
  logic                                      making_music;
  logic                                      done;

  modport master (
    output ce, notes_flat, loop_en,
    input  pwm, making_music, done
  );

  modport slave (
    input  ce, notes_flat, loop_en,
    output pwm, making_music, done
  );
endinterface

// File: rtl/note_sequencer_pwm.sv
// note_sequencer_pwm: captures a buffer of NUM_NOTES {pitch, dur} entries
// while ce is high, then plays them as a square-wave tone on pwm.
// Optional feature macro: ARTICULATION_GAP_EN inserts GAP_CYCLES silent
// cycles after every note except the final note of non-loop playback.
// The interface instance must use the same NUM_NOTES/PITCH_W/DUR_W.
module note_sequencer_pwm #(
  parameter int unsigned NUM_NOTES      = 5,
  parameter int unsigned PITCH_W        = 4,
  parameter int unsigned DUR_W          = 4,
  parameter int unsigned TICKS_PER_BEAT = 100000,
  parameter int unsigned HALF_STEP      = 1000,
  parameter int unsigned GAP_CYCLES     = 5000
) (
  input logic                clk,
  input logic                nreset,
  note_sequencer_pwm_if.slave bus
);

  localparam int unsigned E        = PITCH_W + DUR_W;
  localparam int unsigned BUF_W    = NUM_NOTES * E;
  localparam int unsigned IDX_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int unsigned NOTE_MAX = (2 ** DUR_W) * TICKS_PER_BEAT;
  localparam int unsigned NOTE_W   = $clog2(NOTE_MAX + 1);
  localparam int unsigned TONE_MAX = ((2 ** PITCH_W) - 1) * HALF_STEP;
  localparam int unsigned TONE_W   = $clog2(TONE_MAX + 1);

  // Elaboration-time parameter sanity checks
  if (NUM_NOTES < 1 || TICKS_PER_BEAT < 1 || HALF_STEP < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("note_sequencer_pwm: NUM_NOTES, TICKS_PER_BEAT, HALF_STEP, GAP_CYCLES must be >= 1");
  end

`ifdef ARTICULATION_GAP_EN
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HOLD, PLAY, GAP} state_t;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, HOLD, PLAY} state_t;
`endif

  state_t             state;
  logic [BUF_W-1:0]   buf_q;
  logic [IDX_W-1:0]   idx;
  logic [NOTE_W-1:0]  note_cnt;
  logic [TONE_W-1:0]  tone_cnt;
  logic               pwm_q;
  logic               mm_q;
  logic               done_q;

  logic [E-1:0]       cur;
  logic [PITCH_W-1:0] pitch;
  logic [DUR_W-1:0]   dur;
  logic [NOTE_W-1:0]  note_last;
  logic [TONE_W-1:0]  tone_last;
  logic               note_end;
  logic               is_last;

  // Decode the current entry and its note-length / half-period terminal counts
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (IDX_W'(i) == idx) cur = buf_q[i*E +: E];
    end
    pitch     = cur[E-1:DUR_W];
    dur       = cur[DUR_W-1:0];
    note_last = NOTE_W'((32'(dur) + 32'd1) * TICKS_PER_BEAT - 32'd1);
    tone_last = TONE_W'(32'(pitch) * HALF_STEP - 32'd1);
    note_end  = (note_cnt == note_last);
    is_last   = (idx == IDX_W'(NUM_NOTES - 1));
  end

  // Sequencer FSM with registered outputs; reset beats ce, ce beats playback
  always_ff @(posedge clk) begin
    if (nreset) begin
      state    <= IDLE;
      buf_q    <= '0;
      idx      <= '0;
      note_cnt <= '0;
      tone_cnt <= '0;
`ifdef ARTICULATION_GAP_EN
      gap_cnt  <= '0;
`endif
      pwm_q    <= 1'b0;
      mm_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.ce) begin
        state    <= HOLD;
        buf_q    <= bus.notes_flat;
        idx      <= '0;
        note_cnt <= '0;
        tone_cnt <= '0;
`ifdef ARTICULATION_GAP_EN
        gap_cnt  <= '0;
`endif
        pwm_q    <= 1'b0;
        mm_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pwm_q <= 1'b0;
            mm_q  <= 1'b0;
          end
          HOLD: begin
            state    <= PLAY;
            idx      <= '0;
            note_cnt <= '0;
            tone_cnt <= '0;
            pwm_q    <= 1'b0;
            mm_q     <= 1'b1;
          end
          PLAY: begin
            if (note_end) begin
              note_cnt <= '0;
              tone_cnt <= '0;
              pwm_q    <= 1'b0;
              if (is_last && !bus.loop_en) begin
                state  <= IDLE;
                idx    <= '0;
                mm_q   <= 1'b0;
                done_q <= 1'b1;
              end else begin
                idx <= is_last ? '0 : idx + IDX_W'(1);
`ifdef ARTICULATION_GAP_EN
                state   <= GAP;
                gap_cnt <= '0;
`endif
              end
            end else begin
              note_cnt <= note_cnt + NOTE_W'(1);
              if (pitch != '0) begin
                if (tone_cnt == tone_last) begin
                  tone_cnt <= '0;
                  pwm_q    <= ~pwm_q;
                end else begin
                  tone_cnt <= tone_cnt + TONE_W'(1);
                end
              end
            end
          end
`ifdef ARTICULATION_GAP_EN
          GAP: begin
            pwm_q <= 1'b0;
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              state   <= PLAY;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
`endif
          default: begin
            state <= IDLE;
            pwm_q <= 1'b0;
            mm_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pwm          = pwm_q;
  assign bus.making_music = mm_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_note_sequencer_pwm.sv
// Self-checking bench for note_sequencer_pwm. Expected waveforms are built
// per cycle from the note rules: length (dur+1)*TPB, tone bit (k/H)%2.
module tb_note_sequencer_pwm;
  localparam int NN  = 5;
  localparam int PW  = 4;
  localparam int DW  = 4;
  localparam int TPB = 4;
  localparam int HS  = 2;
`ifdef ARTICULATION_GAP_EN
  localparam int GAPC = 3;
`else
  localparam int GAPC = 0;
`endif
  localparam int E  = PW + DW;
  localparam int BW = NN * E;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  note_sequencer_pwm_if #(.NUM_NOTES(NN), .PITCH_W(PW), .DUR_W(DW)) bus ();

  note_sequencer_pwm #(
    .NUM_NOTES(NN), .PITCH_W(PW), .DUR_W(DW),
    .TICKS_PER_BEAT(TPB), .HALF_STEP(HS), .GAP_CYCLES(3)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int note_start[NN];
  int final_start;

  function automatic logic [BW-1:0] rand_buf();
    return BW'({$urandom(), $urandom()});
  endfunction

  // Expected pwm per cycle for `loops` looped passes followed by one final pass
  task automatic build(input logic [BW-1:0] b, input int loops);
    logic [E-1:0] ent;
    int pitch, dur, len, h;
    exp_q.delete();
    for (int p = 0; p <= loops; p++) begin
      if (p == loops) final_start = exp_q.size();
      for (int i = 0; i < NN; i++) begin
        ent   = E'(b >> (i * E));
        pitch = int'(ent[E-1:DW]);
        dur   = int'(ent[DW-1:0]);
        len   = (dur + 1) * TPB;
        h     = pitch * HS;
        if (p == 0) note_start[i] = exp_q.size();
        for (int k = 0; k < len; k++)
          exp_q.push_back((pitch == 0) ? 1'b0 : bit'((k / h) % 2));
        if (!(p == loops && i == NN - 1))
          for (int g = 0; g < GAPC; g++) exp_q.push_back(1'b0);
      end
    end
  endtask

  task automatic check_out(input logic [2:0] req, input string tag);
    checks++;
    if ({bus.pwm, bus.making_music, bus.done} !== req) begin
      errors++;
      $display("FAIL %s: pwm/mm/done=%b%b%b required %b", tag,
               bus.pwm, bus.making_music, bus.done, req);
    end
  endtask

  task automatic load(input logic [BW-1:0] b);
    @(posedge clk); #1;
    bus.ce = 1'b1;
    bus.notes_flat = b;
    @(posedge clk); #1;
    check_out(3'b000, "hold_outputs");
    @(posedge clk); #1;
    bus.ce = 1'b0;
    bus.notes_flat = rand_buf();
  endtask

  task automatic expect_stream(input int n, input int drop_at, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.notes_flat = rand_buf();
      if (c == drop_at) bus.loop_en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.pwm !== exp_q[c] || bus.making_music !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: pwm/mm/done=%b%b%b required %b10", tag, c,
                 bus.pwm, bus.making_music, bus.done, exp_q[c]);
      end
    end
  endtask

  task automatic expect_done(input string tag);
    @(posedge clk); @(negedge clk);
    check_out(3'b001, {tag, "_done"});
    @(posedge clk); @(negedge clk);
    check_out(3'b000, {tag, "_after_done"});
  endtask

  task automatic play_full(input logic [BW-1:0] b, input int loops, input string tag);
    bus.loop_en = (loops > 0);
    load(b);
    build(b, loops);
    expect_stream(exp_q.size(), (loops > 0) ? final_start : -1, tag);
    expect_done(tag);
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    bus.ce = 1'b1;
    bus.loop_en = 1'b0;
    bus.notes_flat = 40'h0123456789;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(3'b000, "reset_outputs");
    nreset = 1'b0;
    bus.ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check_out(3'b000, "reset_no_load");
    end
  endtask

  task automatic test_decode();
    play_full(40'h0123456789, 0, "decode_fixed");
    for (int r = 0; r < 3; r++) play_full(rand_buf(), 0, "decode_rand");
  endtask

  task automatic test_loop();
    play_full(40'h0000000010, 3, "loop_fixed");
    play_full(rand_buf(), 1, "loop_rand");
  endtask

  task automatic test_abort();
    logic [BW-1:0] a, b2;
    int len2;
    a  = rand_buf();
    b2 = rand_buf();
    bus.loop_en = 1'b0;
    load(a);
    build(a, 0);
    len2 = note_start[3] - note_start[2] - GAPC;
    expect_stream(note_start[2] + len2 / 2, -1, "abort_pre");
    bus.ce = 1'b1;
    bus.notes_flat = b2;
    @(posedge clk); @(negedge clk);
    check_out(3'b000, "abort_outputs");
    @(posedge clk); #1;
    bus.ce = 1'b0;
    bus.notes_flat = rand_buf();
    build(b2, 0);
    expect_stream(exp_q.size(), -1, "abort_reload");
    expect_done("abort_reload");
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] a;
    int len1;
    a = rand_buf();
    bus.loop_en = 1'b1;
    load(a);
    build(a, 0);
    len1 = note_start[2] - note_start[1] - GAPC;
    expect_stream(note_start[1] + len1 / 2, -1, "rstmid_pre");
    nreset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_out(3'b000, "rstmid_outputs");
    nreset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      check_out(3'b000, "rstmid_idle");
    end
    bus.loop_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    play_full(40'h0000001010, 0, "b2b_short");
    play_full(rand_buf(), 0, "b2b_rand");
  endtask

  initial begin
    bus.ce = 1'b0;
    bus.loop_en = 1'b0;
    bus.notes_flat = '0;
    nreset = 1'b1;
    test_reset();
    test_decode();
    test_loop();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/note_sequencer_pwm.md
Name: note_sequencer_pwm

Overview:
Parametrised successor to the single-shot 5-note music player. Captures a flattened buffer of NUM_NOTES note entries from the MCU interface under ce, then plays the entries in order as a square-wave PWM tone.
Generalised in note count, pitch/duration width, tempo and tone scaling. Adds loop playback, rests and a one-cycle done pulse.
Sits between the MCU receive logic and the speaker driver pin.

Parameters:
NUM_NOTES, 5, number of note entries in the buffer (>=1)
PITCH_W, 4, pitch field width per entry
DUR_W, 4, duration field width per entry
TICKS_PER_BEAT, 100000, clock cycles per duration unit (>=1)
HALF_STEP, 1000, clock cycles per pitch unit of PWM half-period (>=1)
GAP_CYCLES, 5000, silent cycles between notes; used only when ARTICULATION_GAP_EN is defined (>=1)

Ports:
clk  in  1  system clock; all logic is on its rising edge
nreset  in  1  synchronous, active-high reset (despite the name, 1 = reset)
ce  in  1  load strobe; while 1, the buffer is captured and playback is held
notes_flat  in  NUM_NOTES*(PITCH_W+DUR_W)  flattened note buffer
loop_en  in  1  1 = restart at note 0 after the last note instead of stopping
pwm  out  1  tone output, registered
making_music  out  1  high while playback is active, registered
done  out  1  one-cycle pulse when non-loop playback finishes, registered

Behaviour:
- Entry i occupies notes_flat[(i+1)*E-1 : i*E], with E = PITCH_W+DUR_W. Note 0 is the least-significant entry.
- Entry layout is {pitch, dur}: pitch in the upper PITCH_W bits, dur in the lower DUR_W bits.
- Note length is (dur+1)*TICKS_PER_BEAT cycles. Size the counter for the maximum value; no overflow or wrap is allowed.
- pitch==0 is a rest: pwm=0 for the whole note.
- pitch>0: half-period H = pitch*HALF_STEP cycles.
  - pwm is 0 in the first cycle of each note and toggles after every H cycles.
  - The tone counter restarts at each note boundary.
- FSM states:
  - IDLE: outputs 0.
  - HOLD: ce=1; notes_flat is registered every cycle and outputs are 0.
  - PLAY.
  - GAP: only with ARTICULATION_GAP_EN.
- Transitions:
  - Any state with ce=1 goes to HOLD.
  - HOLD with ce=0 goes to PLAY with idx=0 and counters cleared.
  - making_music=1 from the first edge at which ce is sampled 0.
  - PLAY at the end of a note with idx<NUM_NOTES-1: idx+1.
  - End of the last note with loop_en=1: idx wraps to 0 and making_music stays 1.
  - End of the last note with loop_en=0: go to IDLE; making_music=0, pwm=0 and done=1 for exactly one cycle on that same edge.
- loop_en is sampled only at the end of the last note.
- ce during PLAY/GAP aborts playback immediately. No done pulse; outputs go to 0 next edge; the new buffer plays after ce falls.
- Playback uses only the registered buffer. notes_flat changing while ce=0 has no effect.
- nreset has priority over ce.
- Reset values: state=IDLE, idx=0, all counters=0, buffer=0, pwm=0, making_music=0, done=0. Reset mid-playback stops it on the next edge with no done pulse.
- Latency from ce falling to the first pwm cycle of note 0 is 1 clock.

Optional Feature:
ARTICULATION_GAP_EN
- Defined:
  - After each note except the final non-loop note, the FSM enters GAP for GAP_CYCLES cycles: pwm=0, making_music stays 1.
  - A gap is also inserted before wrapping to note 0 in loop mode.
  - ce during GAP aborts, as it does in PLAY.
- Undefined: the GAP state and its counter are absent. Notes are back-to-back with no idle cycle between them.

Test Plan:
All scenarios use TICKS_PER_BEAT=4, HALF_STEP=2, and GAP undefined unless stated.
1. Reset: nreset=1 for 2 clocks with ce=1 -> pwm=0, making_music=0, done=0; no load occurs.
2. Decode/timing: ce=1 for 2 clocks with notes_flat=40'h0123456789, then ce=0, loop_en=0:
   - note0 (pitch 8, dur 9): 40 cycles, pwm pattern 16 low, 16 high, 8 low.
   - Then notes 0x67, 0x45, 0x23.
   - note4=0x01 is a rest of 8 cycles.
   - done=1 for one cycle at total cycle 40+32+24+16+8=120; making_music drops on the same edge.
3. Loop: notes_flat=40'h0000000010, loop_en=1:
   - note0 pitch 1 dur 0: pwm 0,0,1,1 then 16 rest cycles per pass, repeating.
   - done never pulses; setting loop_en=0 gives done after the current pass.
4. Abort/reload: ce=1 mid-note2 with a new buffer -> outputs 0 next edge; after ce falls, playback starts at the new note0 with no done pulse.
5. Reset mid-playback: nreset=1 during note1 -> all outputs 0 next edge; after nreset=0 the block stays IDLE until ce.
6. ARTICULATION_GAP_EN with GAP_CYCLES=3, buffer 40'h0000001010, loop_en=0:
   - pattern 4 tone, 3 gap, 4 tone, 3 gap, then 3 rest notes of 4 cycles with gaps.
   - done at cycle 4+3+4+3+4+3+4+3+4=32.
